// File: rtl/sr_flipflop_bank.sv
// Bank of independent clocked set/reset flip-flops with selectable S=R=1
// resolution, registered edge pulses and sticky conflict monitoring.
module sr_flipflop_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict_flags,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Unsupported MODE values fall back to hold.
    localparam logic [1:0] MODE_EFF = (MODE >= 0 && MODE <= 3) ? 2'(MODE) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] conflict_s;
    logic             any_conflict_s;

    // Per-channel next state and the edge pulses derived from it.
    always_comb begin
        q_d = q_q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s[i], r[i]})
                    2'b10:   q_d[i] = 1'b1;
                    2'b01:   q_d[i] = 1'b0;
                    2'b11: begin
                        case (MODE_EFF)
                            2'd1:    q_d[i] = 1'b1;
                            2'd2:    q_d[i] = 1'b0;
                            2'd3:    q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end else begin
            q_d = q_q;
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    // Conflict detection: a clear in the same cycle as a conflict lets the new event win.
    always_comb begin
        conflict_s     = en ? (s & r) : {WIDTH{1'b0}};
        any_conflict_s = |conflict_s;
        flags_d        = (clr_err ? {WIDTH{1'b0}} : flags_q) | conflict_s;
        cnt_d          = cnt_q;
        if (clr_err) begin
            cnt_d = any_conflict_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (any_conflict_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State register; reset lands on RESET_VAL without producing edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RESET_VAL;
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            flags_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q              = q_q;
    assign q_bar          = ~q_q;
    assign rise           = rise_q;
    assign fall           = fall_q;
    assign conflict_flags = flags_q;
    assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Directed bench: five 4-channel instances (MODE 0..3 plus out-of-range 7)
// share stimulus; expected values are hand-computed constants.
module tb_sr_flipflop_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr_err;
    logic [3:0] q_o     [5];
    logic [3:0] qb_o    [5];
    logic [3:0] rise_o  [5];
    logic [3:0] fall_o  [5];
    logic [3:0] flags_o [5];
    logic [2:0] cnt_o   [5];

    int n_cmp;
    int n_err;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sr_flipflop_bank #(
            .WIDTH(4),
            .MODE((g == 4) ? 7 : g),
            .RESET_VAL(4'b0101),
            .CNT_W(3)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .en(en),
            .s(s),
            .r(r),
            .clr_err(clr_err),
            .q(q_o[g]),
            .q_bar(qb_o[g]),
            .rise(rise_o[g]),
            .fall(fall_o[g]),
            .conflict_flags(flags_o[g]),
            .conflict_cnt(cnt_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
        en      = e;
        s       = sv;
        r       = rv;
        clr_err = c;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("rst_q%0d", k), 32'(q_o[k]), 32'h5);
            check_val($sformatf("rst_qb%0d", k), 32'(qb_o[k]), 32'ha);
        end
        check_val("rst_rise", 32'(rise_o[0]), 32'h0);
        check_val("rst_fall", 32'(fall_o[0]), 32'h0);
        check_val("rst_flags", 32'(flags_o[0]), 32'h0);
        check_val("rst_cnt", 32'(cnt_o[0]), 32'h0);
        rst = 1'b0;

        // clear all channels, then set/reset sequence
        drive(1'b1, 4'b0000, 4'b1111, 1'b0);
        tick();
        check_val("clr_q", 32'(q_o[0]), 32'h0);
        check_val("clr_fall", 32'(fall_o[0]), 32'h5);
        drive(1'b1, 4'b0011, 4'b0000, 1'b0);
        tick();
        check_val("set_q", 32'(q_o[0]), 32'h3);
        check_val("set_qb", 32'(qb_o[0]), 32'hc);
        check_val("set_rise", 32'(rise_o[0]), 32'h3);
        check_val("set_fall", 32'(fall_o[0]), 32'h0);
        drive(1'b1, 4'b0000, 4'b0001, 1'b0);
        tick();
        check_val("res_q", 32'(q_o[0]), 32'h2);
        check_val("res_fall", 32'(fall_o[0]), 32'h1);
        check_val("res_rise", 32'(rise_o[0]), 32'h0);
        drive(1'b1, 4'b0010, 4'b0000, 1'b0);
        tick();
        check_val("reset_again_q", 32'(q_o[0]), 32'h2);
        check_val("reset_again_rise", 32'(rise_o[0]), 32'h0);
        check_val("reset_again_fall", 32'(fall_o[0]), 32'h0);
        check_val("noconf_flags", 32'(flags_o[0]), 32'h0);

        // S=R=1 resolution per mode from q=0101
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        check_val("m0_q1", 32'(q_o[0]), 32'h5);
        check_val("m1_q1", 32'(q_o[1]), 32'hf);
        check_val("m2_q1", 32'(q_o[2]), 32'h0);
        check_val("m3_q1", 32'(q_o[3]), 32'ha);
        check_val("m7_q1", 32'(q_o[4]), 32'h5);
        check_val("m1_rise", 32'(rise_o[1]), 32'ha);
        check_val("m2_fall", 32'(fall_o[2]), 32'h5);
        check_val("m3_rise", 32'(rise_o[3]), 32'ha);
        check_val("m3_fall", 32'(fall_o[3]), 32'h5);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("m%0d_flags", k), 32'(flags_o[k]), 32'hf);
            check_val($sformatf("m%0d_cnt1", k), 32'(cnt_o[k]), 32'h1);
        end
        tick();
        check_val("m0_q2", 32'(q_o[0]), 32'h5);
        check_val("m1_q2", 32'(q_o[1]), 32'hf);
        check_val("m1_rise2", 32'(rise_o[1]), 32'h0);
        check_val("m2_q2", 32'(q_o[2]), 32'h0);
        check_val("m3_q2", 32'(q_o[3]), 32'h5);
        check_val("m3_rise2", 32'(rise_o[3]), 32'h5);
        check_val("m3_fall2", 32'(fall_o[3]), 32'ha);
        check_val("m0_cnt2", 32'(cnt_o[0]), 32'h2);

        // clear collides with a new conflict on channel 2
        drive(1'b1, 4'b0100, 4'b0100, 1'b1);
        tick();
        check_val("coll_flags", 32'(flags_o[0]), 32'h4);
        check_val("coll_cnt", 32'(cnt_o[0]), 32'h1);

        // multiple channels in one cycle count once
        drive(1'b1, 4'b0011, 4'b0011, 1'b0);
        tick();
        check_val("multi_cnt", 32'(cnt_o[0]), 32'h2);
        check_val("multi_flags", 32'(flags_o[0]), 32'h7);

        // saturation at 7
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check_val("cnt6", 32'(cnt_o[0]), 32'h6);
        tick();
        check_val("cnt7", 32'(cnt_o[0]), 32'h7);
        for (int k = 0; k < 5; k++) tick();
        check_val("cnt_sat", 32'(cnt_o[0]), 32'h7);
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        check_val("clr_cnt", 32'(cnt_o[0]), 32'h0);
        check_val("clr_flags", 32'(flags_o[0]), 32'h0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);

        // enable gating
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("en0_q%0d", k), 32'(q_o[0]), 32'h5);
            check_val($sformatf("en0_rise%0d", k), 32'(rise_o[0]), 32'h0);
        end
        drive(1'b0, 4'b1111, 4'b1111, 1'b0);
        tick();
        check_val("en0_conf_q", 32'(q_o[3]), 32'h5);
        check_val("en0_conf_flags", 32'(flags_o[0]), 32'h0);
        check_val("en0_conf_cnt", 32'(cnt_o[0]), 32'h0);
        drive(1'b1, 4'b1111, 4'b0000, 1'b0);
        tick();
        check_val("en1_q", 32'(q_o[0]), 32'hf);
        check_val("en1_rise", 32'(rise_o[0]), 32'ha);

        // asynchronous reset mid-cycle after a conflict
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        check_val("pre_rst_flags", 32'(flags_o[1]), 32'hf);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("arst_q%0d", k), 32'(q_o[k]), 32'h5);
            check_val($sformatf("arst_qb%0d", k), 32'(qb_o[k]), 32'ha);
            check_val($sformatf("arst_flags%0d", k), 32'(flags_o[k]), 32'h0);
            check_val($sformatf("arst_cnt%0d", k), 32'(cnt_o[k]), 32'h0);
        end
        check_val("arst_rise", 32'(rise_o[1]), 32'h0);
        check_val("arst_fall", 32'(fall_o[1]), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_q", 32'(q_o[1]), 32'h5);
        check_val("post_rst_rise", 32'(rise_o[1]), 32'h0);
        check_val("post_rst_fall", 32'(fall_o[1]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_flipflop_bank.md
# sr_flipflop_bank

Parametrised bank of WIDTH independent clocked set/reset flip-flops with a selectable S=R=1 resolution mode, per-channel edge pulses and conflict monitoring. It generalises the single clocked SR flip-flop into a multi-channel, mode-configurable status/flag register. It sits beside control logic that raises and clears status bits, for example interrupt-pending or sticky error flags.

## Interface
- WIDTH, 8, number of channels (1..32)
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK behaviour)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of the conflict counter
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  update enable; s/r are ignored when low
- s  input  WIDTH  per-channel set request
- r  input  WIDTH  per-channel reset request
- clr_err  input  1  synchronous clear of conflict_flags and conflict_cnt
- q  output  WIDTH  registered channel state
- q_bar  output  WIDTH  always ~q (no extra register)
- rise  output  WIDTH  one-cycle pulse on each 0->1 transition of q
- fall  output  WIDTH  one-cycle pulse on each 1->0 transition of q
- conflict_flags  output  WIDTH  sticky per-channel S=R=1 indicator
- conflict_cnt  output  CNT_W  saturating count of conflict cycles

## Operation
- Channels are fully independent and share only en, clr_err and the counter.
- Per channel with en=1, sampled at posedge: s=0,r=0 holds q; s=1,r=0 sets q to 1; s=0,r=1 sets q to 0; s=1,r=1 resolves per MODE (0 hold, 1 q=1, 2 q=0, 3 q=~q).
- With en=0, q holds and no conflict is recorded.
- Conflict is defined as en=1 and s[i]=r[i]=1. It is detected in every MODE; MODE only changes the effect on q.
  - On a conflict, conflict_flags[i] is set and stays set until clr_err or rst.
  - conflict_cnt increments by 1 per cycle in which any channel conflicts. It counts cycles, not channels, and saturates at 2^CNT_W-1 with no wrap.
- clr_err=1 zeroes the flags and the counter on the next edge. If a conflict occurs in the same cycle, the new event wins: the flag is set for the conflicting channel only and conflict_cnt becomes 1.
- rise/fall are registered. rise[i]=q_next[i]&~q[i] and fall[i]=~q_next[i]&q[i], captured at the same edge as q. Repeated set on an already-set channel gives no pulse.
- Out-of-range MODE values are treated as MODE 0.

## Timing
- Latency: s/r to q is 1 cycle. q_bar follows q combinationally in the same cycle.
- rise/fall are high for exactly one cycle, aligned with the cycle in which the new q is visible.
- conflict_flags/conflict_cnt update 1 cycle after the offending s/r sample.
- Reset values: q=RESET_VAL, q_bar=~RESET_VAL, rise=0, fall=0, conflict_flags=0, conflict_cnt=0.
- Reset acts immediately on assertion, not at the next edge, including mid-operation.
- The transition into RESET_VAL caused by reset does not generate rise/fall pulses.
- First update after deassertion: the first posedge with rst=0 samples inputs normally.
- No state machine beyond the per-channel bit, the counter and the flags; there are no multi-cycle operations.

## Test plan
- Reset, WIDTH=4, RESET_VAL=4'b0101: assert rst mid-cycle -> q=0101 and q_bar=1010 before the next edge; rise=fall=flags=cnt=0.
- Set/reset, MODE=0, en=1: s=0011,r=0000 then s=0000,r=0001 -> q=0011 with rise=0011 for one cycle, then q=0010 with fall=0001 for one cycle.
- S=R=1 per mode from q=0101 with s=r=1111:
  - MODE 0 -> q=0101.
  - MODE 1 -> q=1111.
  - MODE 2 -> q=0000.
  - MODE 3 -> q=1010 on the first edge and back to 0101 on the second.
  - In all modes, flags=1111 and cnt increments by 1 per cycle.
- Counter saturation, CNT_W=3: hold s=r=0001 with en=1 for 10 cycles -> cnt reaches 7 and stays 7. Then clr_err=1 with s=r=0 -> cnt=0, flags=0.
- clr_err collision, flags=1111: clr_err=1 while s=r=0100 -> flags=0100, cnt=1.
- Enable gating: en=0 with s=1111,r=0000 for 3 cycles -> q unchanged, no rise pulses, no conflicts even with s=r=1111. Then en=1 -> q=1111 on the next edge.
